imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 18 +
 rtl/word_assembler.sv | 44 ++++
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// States, header size and word geometry live here.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    WRITE,
    RUN,
    ERR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 8 * HDR_BYTES;

endpackage

// File: rtl/word_assembler.sv
// Shifts program bytes into a 32-bit big-endian word and
// tracks how many bytes of the current word have arrived.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  // High when the next shifted byte completes the word
  assign word_full_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory
// and holds the CPU in reset until a full program is present.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        reload,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             ready_q, ready_d;
  logic             init_q, init_d;
  logic             crst_q, crst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             clr, shift;
  logic             word_full;
  logic             run_hold;
  logic [CNT_W-1:0] n_full;

  assign xfer   = byte_valid & ready_q;
  assign n_full = {n_q[15:8], byte_data};

  word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clr),
    .shift_i     (shift),
    .byte_i      (byte_data),
    .word_o      (instruction_initialize_data),
    .word_full_o (word_full)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    clr     = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      HDR0: begin
        if (xfer) begin
          n_d[15:8] = byte_data;
          state_d   = HDR1;
        end
      end
      HDR1: begin
        if (xfer) begin
          n_d = n_full;
          if (n_full == '0) begin
            state_d = RUN;
          end else if (n_full > MAX_N) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
            wcnt_d  = '0;
            clr     = 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          shift = 1'b1;
          if (word_full) state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 32'd4;
        wcnt_d  = wcnt_q + 1'b1;
        state_d = (wcnt_d == n_q) ? RUN : DATA;
      end
      RUN: begin
        if (reload) begin
          state_d = HDR0;
          addr_d  = BASE_ADDR;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: state_d = HDR0;
    endcase

    // Release lags RUN entry by a cycle; reload drops it at once
    run_hold = (state_q == RUN) && !reload;
    ready_d  = (state_d == HDR0) || (state_d == HDR1) ||
               (state_d == DATA);
    init_d   = (state_d == WRITE);
    done_d   = run_hold;
    crst_d   = !run_hold;
    err_d    = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HDR0;
      n_q     <= '0;
      wcnt_q  <= '0;
      addr_q  <= BASE_ADDR;
      ready_q <= 1'b0;
      init_q  <= 1'b0;
      crst_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      init_q  <= init_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign byte_ready                     = ready_q;
  assign initialize                     = init_q;
  assign instruction_initialize_address = addr_q;
  assign cpu_rst                        = crst_q;
  assign done                           = done_q;
  assign error                          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for one load,
// plus sequences for reload, empty, error and reset cases.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic        initialize;
  logic [31:0] instruction_initialize_data;
  logic [31:0] instruction_initialize_address;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] wlog[$];

  imem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (256)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .byte_valid                     (byte_valid),
    .byte_data                      (byte_data),
    .byte_ready                     (byte_ready),
    .reload                         (reload),
    .initialize                     (initialize),
    .instruction_initialize_data    (instruction_initialize_data),
    .instruction_initialize_address (instruction_initialize_address),
    .cpu_rst                        (cpu_rst),
    .done                           (done),
    .error                          (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst && initialize)
      wlog.push_back({instruction_initialize_address,
                      instruction_initialize_data});

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        init;
    logic [31:0] data;
    logic [31:0] addr;
    logic        done;
    logic        crst;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t mk(logic v, logic [7:0] d,
                              logic rdy, logic init,
                              logic [31:0] data,
                              logic [31:0] addr,
                              logic dn, logic crst);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.init = init;
    r.data = data; r.addr = addr;
    r.done = dn; r.crst = crst;
    return r;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b0;
    reload = 1'b0;
    @(negedge clk);
    check("reset_outs",
          {byte_ready, initialize, cpu_rst, done, error},
          5'b00100);
    check("reset_data", instruction_initialize_data, 0);
    check("reset_addr", instruction_initialize_address, 0);
    rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc = 0;
    int guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      if (rnd && $urandom_range(0, 1) == 0) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
      end
      acc = byte_valid && byte_ready;
      @(posedge clk);
      #1 byte_valid = 1'b0;
      guard++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte_timeout: byte %0h not taken", b);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, done, 1'b1);
  endtask

  logic [7:0] s2[10];
  logic [7:0] s1[6];

  initial begin
    rst = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    reload = 1'b0;

    s2 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
           8'h05, 8'h8C, 8'h01, 8'h00, 8'h00};
    s1 = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    tv[0]  = mk(0, 8'h00, 1, 0, 0, 0, 0, 1);
    tv[1]  = mk(1, 8'h00, 1, 0, 0, 0, 0, 1);
    tv[2]  = mk(1, 8'h02, 1, 0, 0, 0, 0, 1);
    tv[3]  = mk(1, 8'h20, 1, 0, 0, 0, 0, 1);
    tv[4]  = mk(1, 8'h08, 1, 0, 0, 0, 0, 1);
    tv[5]  = mk(1, 8'h00, 1, 0, 0, 0, 0, 1);
    tv[6]  = mk(1, 8'h05, 0, 1, 32'h2008_0005, 32'h0, 0, 1);
    tv[7]  = mk(1, 8'hAA, 1, 0, 0, 0, 0, 1);
    tv[8]  = mk(1, 8'h8C, 1, 0, 0, 0, 0, 1);
    tv[9]  = mk(1, 8'h01, 1, 0, 0, 0, 0, 1);
    tv[10] = mk(1, 8'h00, 1, 0, 0, 0, 0, 1);
    tv[11] = mk(0, 8'h55, 1, 0, 0, 0, 0, 1);
    tv[12] = mk(1, 8'h00, 0, 1, 32'h8C01_0000, 32'h4, 0, 1);
    tv[13] = mk(0, 8'h00, 0, 0, 0, 0, 0, 1);
    tv[14] = mk(0, 8'h00, 0, 0, 0, 0, 1, 0);
    tv[15] = mk(0, 8'h00, 0, 0, 0, 0, 1, 0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      byte_valid = tv[i].v;
      byte_data  = tv[i].d;
      @(negedge clk);
      check($sformatf("tbl%0d_ctl", i),
            {byte_ready, initialize, done, cpu_rst, error},
            {tv[i].rdy, tv[i].init, tv[i].done, tv[i].crst, 1'b0});
      if (tv[i].init)
        check($sformatf("tbl%0d_word", i),
              {instruction_initialize_address,
               instruction_initialize_data},
              {tv[i].addr, tv[i].data});
    end

    // reload from RUN, then a single all-ones word
    wlog.delete();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_hold", {cpu_rst, done, byte_ready}, 3'b101);
    foreach (s1[i]) send_byte(s1[i], 0);
    wait_done("reload_done", 10);
    check("reload_nwr", wlog.size(), 1);
    if (wlog.size() >= 1)
      check("reload_wr", wlog[0], {32'h0, 32'hFFFF_FFFF});

    // empty program
    do_reset();
    wlog.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_done("n0_done", 5);
    check("n0_crst", cpu_rst, 1'b0);
    check("n0_nwr", wlog.size(), 0);

    // random stalls on the source
    do_reset();
    wlog.delete();
    foreach (s2[i]) send_byte(s2[i], 1);
    wait_done("rnd_done", 10);
    check("rnd_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("rnd_wr0", wlog[0], {32'h0, 32'h2008_0005});
      check("rnd_wr1", wlog[1], {32'h4, 32'h8C01_0000});
    end

    // reset after six bytes, then full resend
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(s2[i], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_outs", {byte_ready, done, cpu_rst, initialize},
          4'b0010);
    @(negedge clk);
    rst = 1'b1;
    wlog.delete();
    foreach (s2[i]) send_byte(s2[i], 0);
    wait_done("abort_done", 10);
    check("abort_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("abort_wr0", wlog[0], {32'h0, 32'h2008_0005});
      check("abort_wr1", wlog[1], {32'h4, 32'h8C01_0000});
    end

    // over-length header: stuck in error
    do_reset();
    wlog.delete();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'h00;
      reload     = (i % 7 == 0);
      check($sformatf("err_c%0d", i),
            {error, byte_ready, cpu_rst, done}, 4'b1010);
    end
    byte_valid = 1'b0;
    reload = 1'b0;
    check("err_nwr", wlog.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
